// File: rtl/aes_stream_loader.sv
// rtl/aes_stream_loader.sv - packs a 32-bit word stream into one cipher_unit block, runs it, streams the result out
module aes_stream_loader #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             key_wr,
  input  logic [2:0]       key_idx,
  input  logic [31:0]      key_data,
  input  logic [1:0]       kl_i,
  input  logic             enc_dec_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             timeout_err,
  output logic             core_clr,
  output logic             core_ck,
  output logic [7:0][31:0] core_key,
  output logic [1:0]       core_kl,
  output logic             core_enc_dec,
  output logic [3:0][31:0] core_state_i,
  input  logic [3:0][31:0] core_state_o,
  input  logic             core_cf
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int            TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       ocnt_q, ocnt_d;
  logic [7:0][31:0] key_q, key_d;
  logic             key_dirty_q, key_dirty_d;
  logic [3:0][31:0] state_i_q, state_i_d;
  logic [3:0][31:0] result_q, result_d;
  logic             enc_dec_q, enc_dec_d;
  logic [1:0]       kl_q, kl_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_err_q, timeout_err_d;

  logic [1:0]       kl_map;
  logic             kl_change;

  // Key length 3 is an alias for 256-bit; a length change forces a round-key reload just like a key write.
  always_comb begin
    kl_map    = (kl_i == 2'd3) ? 2'd2 : kl_i;
    kl_change = (kl_map != kl_q);
  end

  // Next-state logic for the load / start / run / drain sequence and all datapath registers.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ocnt_d        = ocnt_q;
    key_d         = key_q;
    key_dirty_d   = key_dirty_q;
    state_i_d     = state_i_q;
    result_d      = result_q;
    enc_dec_d     = enc_dec_q;
    kl_d          = kl_q;
    timer_d       = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (key_wr) begin
          key_d[key_idx] = key_data;
          key_dirty_d    = 1'b1;
        end
        if (in_valid) begin
          state_i_d[cnt_q] = in_data;
          cnt_d            = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        enc_dec_d   = enc_dec_i;
        kl_d        = kl_map;
        key_dirty_d = 1'b0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        // A completion flag on the last allowed cycle still counts as success.
        if (core_cf) begin
          result_d = core_state_o;
          ocnt_d   = 2'd0;
          state_d  = S_DRAIN;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_LOAD;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          ocnt_d = ocnt_q + 2'd1;
          if (ocnt_q == 2'd3) begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State registers with synchronous reset; the key starts dirty so the first block loads round keys.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q       <= S_LOAD;
      cnt_q         <= 2'd0;
      ocnt_q        <= 2'd0;
      key_q         <= '0;
      key_dirty_q   <= 1'b1;
      state_i_q     <= '0;
      result_q      <= '0;
      enc_dec_q     <= 1'b1;
      kl_q          <= 2'd0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ocnt_q        <= ocnt_d;
      key_q         <= key_d;
      key_dirty_q   <= key_dirty_d;
      state_i_q     <= state_i_d;
      result_q      <= result_d;
      enc_dec_q     <= enc_dec_d;
      kl_q          <= kl_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Handshakes and core controls; the core runs only in RUN and CLR holds it cleared with keys reloading.
  always_comb begin
    in_ready     = !CLR && (state_q == S_LOAD);
    out_valid    = !CLR && (state_q == S_DRAIN);
    out_data     = result_q[ocnt_q];
    timeout_err  = timeout_err_q;
    core_clr     = CLR || (state_q != S_RUN);
    core_ck      = CLR || ((state_q == S_START) && (key_dirty_q || kl_change));
    core_key     = key_q;
    core_kl      = kl_q;
    core_enc_dec = enc_dec_q;
    core_state_i = state_i_q;
  end

endmodule
